// File: rtl/fibo_checker.sv
// Fibonacci stream checker: validates one term per in_valid strobe, pulses match/done,
// latches a sticky error, counts passes and shows the last accepted term on two 7-seg digits.

module fibo_hex7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg_o = 7'b1111111;
    unique case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end
endmodule

module fibo_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 233
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             match,
  output logic             error,
  output logic             done,
  output logic [3:0]       term_idx,
  output logic [7:0]       pass_cnt,
  output logic [6:0]       out1,
  output logic [6:0]       out2
);

  localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

  typedef enum logic [1:0] {EXP0, EXP1, RUN, ERR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       pass_q, pass_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EXP0;
      prev_q  <= '0;
      cur_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      match_q <= match_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    last_d  = last_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;
    // Extra carry bit keeps an overflowing sum from aliasing onto a small term
    sum     = {1'b0, prev_q} + {1'b0, cur_q};

    if (clear) begin
      state_d = EXP0;
      prev_d  = '0;
      cur_d   = '0;
      last_d  = '0;
      idx_d   = '0;
      error_d = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        EXP0: begin
          if (in_data == '0) begin
            match_d = 1'b1;
            last_d  = in_data;
            idx_d   = 4'd1;
            state_d = EXP1;
          end else begin
            error_d = 1'b1;
            state_d = ERR;
          end
        end
        EXP1: begin
          if (in_data == WIDTH'(1)) begin
            match_d = 1'b1;
            last_d  = in_data;
            prev_d  = '0;
            cur_d   = WIDTH'(1);
            idx_d   = 4'd2;
            state_d = RUN;
          end else begin
            error_d = 1'b1;
            state_d = ERR;
          end
        end
        RUN: begin
          if ({1'b0, in_data} == sum) begin
            match_d = 1'b1;
            last_d  = in_data;
            if (in_data == MAX_W) begin
              done_d  = 1'b1;
              pass_d  = pass_q + 8'd1;
              prev_d  = '0;
              cur_d   = '0;
              idx_d   = '0;
              state_d = EXP0;
            end else begin
              prev_d = cur_q;
              cur_d  = in_data;
              idx_d  = idx_q + 4'd1;
            end
          end else begin
            error_d = 1'b1;
            state_d = ERR;
          end
        end
        ERR: ;
        default: begin
          error_d = 1'b1;
          state_d = ERR;
        end
      endcase
    end
  end

  assign match    = match_q;
  assign done     = done_q;
  assign error    = error_q;
  assign term_idx = idx_q;
  assign pass_cnt = pass_q;

  fibo_hex7seg u_seg_lo (.nibble_i(last_q[3:0]), .seg_o(out1));
  fibo_hex7seg u_seg_hi (.nibble_i(last_q[7:4]), .seg_o(out2));

endmodule

// File: doc/fibo_checker.md
Name: fibo_checker

Overview:
- Receiving end of the Fibonacci generator stream.
- Samples one 8-bit term per valid strobe and checks it against the expected Fibonacci sequence 0,1,1,2,3,5,…,MAX.
- Counts accepted terms, flags the first mismatch (sticky), and signals completion when MAX is received.
- Drives two 7-segment digits with the last accepted term, using the team's existing nibble-to-7-segment hex encoder.

Parameters:
- WIDTH, 8, data width of a term.
- MAX, 233, last term of one pass. Must be a Fibonacci number representable in WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  term present on in_data this cycle.
- in_data  input  WIDTH  term under test.
- clear  input  1  synchronous re-arm; same effect as reset, without clearing pass_cnt.
- match  output  1  one-cycle pulse: previous sampled term was correct.
- error  output  1  sticky: a mismatch has been seen.
- done  output  1  one-cycle pulse: term equal to MAX accepted.
- term_idx  output  4  index of the next expected term (0..13 for MAX=233).
- pass_cnt  output  8  completed passes; wraps 255→0.
- out1  output  7  7-seg code, low nibble of last accepted term.
- out2  output  7  7-seg code, high nibble of last accepted term.

Behaviour:
- Reset (async, rst=1) values:
  - state=EXP0, prev=0, cur=0, last=0, term_idx=0, pass_cnt=0.
  - match=0, done=0, error=0.
  - out1/out2 show "0".
- State machine (transitions only on clk edges with in_valid=1, unless noted):
  - EXP0: expects 0.
    - Match → EXP1, term_idx=1.
    - Mismatch → ERR.
  - EXP1: expects 1.
    - Match → RUN, prev=0, cur=1, term_idx=2.
    - Mismatch → ERR.
  - RUN: expects prev+cur.
    - Sum is computed in WIDTH+1 bits and compared zero-extended, so overflow never aliases into a false match.
    - On match: prev←cur, cur←in_data, term_idx+1.
    - If in_data==MAX on match: done pulse, pass_cnt+1, → EXP0, term_idx=0, prev=cur=0.
  - ERR: absorbing.
    - error=1, no further match/done pulses.
    - in_valid is ignored.
    - Exit only via rst or clear.
- Output latency: all outputs are registered.
  - match/done assert in the cycle after the sampling edge, for exactly one cycle.
  - A match and a done for the same term assert together.
- last is updated only on a matching term. out1/out2 are a combinational encode of last (same encoding as the team's hex encoder, 0–F).
- in_valid=0: state, counters and pulses hold. Pulses deassert.
- Back-to-back in_valid on every cycle is supported at full rate. No stall and no ready signal.
- clear (synchronous, highest priority after rst):
  - Next state=EXP0, term_idx=0, prev=cur=last=0, error=0, pulses=0.
  - pass_cnt is retained.
  - A term presented in the same cycle as clear is discarded.
- Reset asserted mid-pass: immediate return to reset values. Any in-flight pulse is dropped.
- Repeated 1: the sequence 0,1,1 is handled by RUN (prev=0, cur=1 → expects 1). The second 1 is not special-cased.
- Sum exceeding MAX without an equal term (e.g. a pass corrupted before MAX) is caught as a mismatch, because MAX is reached exactly on a correct stream.

Test Plan:
- Reset, then drive 0,1,1,2,3,5,8,13,21,34,55,89,144,233 on consecutive cycles → 14 match pulses; done on the 233 term; pass_cnt=1; term_idx=0; out2/out1 show "E","9" (0xE9).
- Two full passes back-to-back, then a third starting with 0 → pass_cnt=2; no error; term_idx=1 after the third 0.
- Drive 0,1,1,2,4 → matches for the first 4 terms; error=1 one cycle after 4 is sampled; out1 shows "2"; subsequent valid 0,1 produce no match.
- In ERR, pulse clear for one cycle with in_valid=1, in_data=5 → error=0, term_idx=0, 5 is discarded; then 0,1 → match pulses resume.
- Drive 0,1,1 with in_valid gaps of 3 idle cycles between terms → state held across gaps; 3 matches; no spurious pulses during idle cycles.
- Assert rst asynchronously (between edges) after term 21 → outputs go to reset values immediately, without waiting for a clock edge; next stream 0,1 accepted from EXP0.
